overlay_sequencer: RTL and testbench

OVERLAY_SEQUENCER -- requirements
Module: overlay_sequencer

---
 rtl/overlay_sequencer.sv | 165 ++++++++++++++++
 tb/tb_overlay_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_sequencer.sv
// Vending overlay sequencer: IDLE blink screen, coin collection with timeout refund,
// and a timed change screen. Registered outputs except the combinational coin_ready.
module overlay_sequencer #(
  parameter int unsigned PRICE0         = 25,
  parameter int unsigned PRICE1         = 50,
  parameter int unsigned PRICE2         = 75,
  parameter int unsigned PRICE3         = 95,
  parameter int unsigned MAX_TOTAL      = 99,
  parameter int unsigned CHANGE_FRAMES  = 180,
  parameter int unsigned TIMEOUT_FRAMES = 600,
  parameter int unsigned BLINK_FRAMES   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       coin_valid,
  input  logic [7:0] coin_value,
  output logic       coin_ready,
  input  logic       item_sel_valid,
  input  logic [1:0] item_sel,
  input  logic       cancel,
  output logic [1:0] state,
  output logic [7:0] total,
  output logic [7:0] change,
  output logic [1:0] selected_item,
  output logic       show_text,
  output logic       vend_pulse
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    COLLECTING = 2'b01,
    CHANGE     = 2'b10
  } state_t;

  localparam int unsigned MAX_A = (CHANGE_FRAMES > TIMEOUT_FRAMES) ? CHANGE_FRAMES : TIMEOUT_FRAMES;
  localparam int unsigned MAX_FRAMES = (MAX_A > BLINK_FRAMES) ? MAX_A : BLINK_FRAMES;
  localparam int CW = $clog2(MAX_FRAMES + 1);

  // Terminal values: the tick that sees cnt == N-1 is the Nth tick.
  localparam logic [CW-1:0] BLINK_LAST   = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_FRAMES - 1);
  localparam logic [CW-1:0] CHANGE_LAST  = CW'(CHANGE_FRAMES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    total_d, change_d;
  logic [1:0]    sel_d;
  logic          show_d, vend_d;
  logic [7:0]    price;
  logic [8:0]    sum9;
  logic          coin_take;

  always_comb begin
    case (item_sel)
      2'd0:    price = 8'(PRICE0);
      2'd1:    price = 8'(PRICE1);
      2'd2:    price = 8'(PRICE2);
      default: price = 8'(PRICE3);
    endcase
  end

  assign sum9 = {1'b0, total} + {1'b0, coin_value};

  // rst_n gating keeps coin_ready low while reset is held, whatever the inputs.
  assign coin_ready = rst_n && ((state_q == IDLE) || (state_q == COLLECTING)) &&
                      !cancel && !item_sel_valid && (sum9 <= 9'(MAX_TOTAL));
  assign coin_take  = coin_valid && coin_ready;
  assign state      = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total;
    change_d = change;
    sel_d   = selected_item;
    show_d  = show_text;
    vend_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_take) begin
          state_d = COLLECTING;
          total_d = coin_value;
          cnt_d   = '0;
          show_d  = 1'b1;
        end else if (frame_tick) begin
          if (cnt_q == BLINK_LAST) begin
            cnt_d  = '0;
            show_d = !show_text;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COLLECTING: begin
        show_d = 1'b1;
        if (cancel) begin
          state_d  = CHANGE;
          change_d = total;
          total_d  = '0;
          cnt_d    = '0;
        end else if (item_sel_valid) begin
          cnt_d = '0;
          if (total >= price) begin
            state_d  = CHANGE;
            change_d = total - price;
            sel_d    = item_sel;
            total_d  = '0;
            vend_d   = 1'b1;
          end
        end else if (coin_take) begin
          total_d = sum9[7:0];
          cnt_d   = '0;
        end else if (frame_tick) begin
          if (cnt_q == TIMEOUT_LAST) begin
            state_d  = CHANGE;
            change_d = total;
            total_d  = '0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CHANGE: begin
        if (frame_tick) begin
          if (cnt_q == CHANGE_LAST) begin
            state_d  = IDLE;
            change_d = '0;
            cnt_d    = '0;
            show_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        show_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      total         <= '0;
      change        <= '0;
      selected_item <= '0;
      show_text     <= 1'b1;
      vend_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      total         <= total_d;
      change        <= change_d;
      selected_item <= sel_d;
      show_text     <= show_d;
      vend_pulse    <= vend_d;
    end
  end

endmodule

// File: tb/tb_overlay_sequencer.sv
// Directed bench for overlay_sequencer with hand-computed expectations.
module tb_overlay_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_value = 8'd0;
  logic       coin_ready;
  logic       item_sel_valid = 1'b0;
  logic [1:0] item_sel = 2'd0;
  logic       cancel = 1'b0;
  logic [1:0] state;
  logic [7:0] total;
  logic [7:0] change;
  logic [1:0] selected_item;
  logic       show_text;
  logic       vend_pulse;

  int checks = 0;
  int errors = 0;

  overlay_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
    .item_sel_valid(item_sel_valid), .item_sel(item_sel), .cancel(cancel),
    .state(state), .total(total), .change(change), .selected_item(selected_item),
    .show_text(show_text), .vend_pulse(vend_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    cyc();
    coin_valid = 1'b0;
  endtask

  task automatic sel(input logic [1:0] i);
    item_sel_valid = 1'b1;
    item_sel = i;
    cyc();
    item_sel_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    // Reset state, with a coin offered that would otherwise be acceptable.
    coin_valid = 1'b1;
    coin_value = 8'd10;
    #12;
    check("rst_state", state, 2'b00);
    check("rst_total", total, 0);
    check("rst_change", change, 0);
    check("rst_sel", selected_item, 0);
    check("rst_show", show_text, 1);
    check("rst_vend", vend_pulse, 0);
    check("rst_coin_ready", coin_ready, 0);
    coin_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // 25+25+25 then item 2 (75): exact change.
    coin(8'd25);
    check("a_total1", total, 25);
    check("a_state1", state, 2'b01);
    coin(8'd25);
    check("a_total2", total, 50);
    coin(8'd25);
    check("a_total3", total, 75);
    sel(2'd2);
    check("a_vend", vend_pulse, 1);
    check("a_change", change, 0);
    check("a_selitem", selected_item, 2);
    check("a_state_chg", state, 2'b10);
    check("a_total0", total, 0);
    cyc();
    check("a_vend_once", vend_pulse, 0);
    ticks(179);
    check("a_chg_179", state, 2'b10);
    ticks(1);
    check("a_idle_180", state, 2'b00);
    check("a_change_clr", change, 0);
    check("a_show_idle", show_text, 1);

    // 50+25, insufficient item 3 then item 1; coin blocked in CHANGE.
    coin(8'd50);
    coin(8'd25);
    sel(2'd3);
    check("b_short_state", state, 2'b01);
    check("b_short_vend", vend_pulse, 0);
    check("b_short_total", total, 75);
    sel(2'd1);
    check("b_change", change, 25);
    check("b_total", total, 0);
    check("b_selitem", selected_item, 1);
    coin_valid = 1'b1;
    coin_value = 8'd10;
    #1;
    check("b_ready_chg", coin_ready, 0);
    cyc();
    coin_valid = 1'b0;
    check("b_total_chg", total, 0);
    ticks(180);
    check("b_idle", state, 2'b00);

    // Build 95, boundary on MAX_TOTAL, then cancel.
    coin(8'd50);
    coin(8'd25);
    coin(8'd20);
    check("c_total95", total, 95);
    coin_valid = 1'b1;
    coin_value = 8'd4;
    #1;
    check("c_ready_99", coin_ready, 1);
    coin_value = 8'd5;
    #1;
    check("c_ready_100", coin_ready, 0);
    coin_value = 8'd10;
    #1;
    check("c_ready_105", coin_ready, 0);
    cyc();
    coin_valid = 1'b0;
    check("c_total_held", total, 95);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    check("c_change", change, 95);
    check("c_state", state, 2'b10);
    check("c_vend", vend_pulse, 0);
    check("c_selitem_kept", selected_item, 1);
    ticks(180);

    // cancel + selection + coin together with total 60.
    coin(8'd50);
    coin(8'd10);
    cancel = 1'b1;
    item_sel_valid = 1'b1;
    item_sel = 2'd0;
    coin_valid = 1'b1;
    coin_value = 8'd10;
    #1;
    check("d_ready", coin_ready, 0);
    cyc();
    cancel = 1'b0;
    item_sel_valid = 1'b0;
    coin_valid = 1'b0;
    check("d_change", change, 60);
    check("d_state", state, 2'b10);
    check("d_vend", vend_pulse, 0);
    check("d_total", total, 0);
    ticks(180);

    // Timeout refund; zero coin on a tick restarts the inactivity count.
    coin(8'd25);
    ticks(300);
    frame_tick = 1'b1;
    coin(8'd0);
    frame_tick = 1'b0;
    check("e_total_zero_coin", total, 25);
    ticks(599);
    check("e_still_coll", state, 2'b01);
    ticks(1);
    check("e_refund_state", state, 2'b10);
    check("e_refund_change", change, 25);
    check("e_refund_vend", vend_pulse, 0);
    ticks(180);
    check("e_idle", state, 2'b00);
    ticks(29);
    check("e_blink_29", show_text, 1);
    ticks(1);
    check("e_blink_30", show_text, 0);
    ticks(30);
    check("e_blink_60", show_text, 1);

    // Asynchronous reset mid-COLLECTING with total 40.
    coin(8'd25);
    coin(8'd15);
    check("f_total40", total, 40);
    coin_valid = 1'b1;
    coin_value = 8'd10;
    #2;
    rst_n = 1'b0;
    #1;
    check("f_rst_state", state, 2'b00);
    check("f_rst_total", total, 0);
    check("f_rst_change", change, 0);
    check("f_rst_show", show_text, 1);
    check("f_rst_vend", vend_pulse, 0);
    check("f_rst_ready", coin_ready, 0);
    rst_n = 1'b1;
    cyc();
    coin_valid = 1'b0;
    check("f_resume_total", total, 10);
    check("f_resume_state", state, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
